// File: rtl/min_compare_seq_if.sv
// Stream bundle for min_compare_seq: sample input handshake, result handshake and C1..C5 flags.
// The min_value signal is only present when MINCMP_MINVAL_EN is defined.
interface min_compare_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  c1;
    logic                  c2;
    logic                  c3;
    logic                  c4;
    logic                  c5;
`ifdef MINCMP_MINVAL_EN
    logic [DATA_WIDTH-1:0] min_value;
`endif

`ifdef MINCMP_MINVAL_EN
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, c1, c2, c3, c4, c5, min_value
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, c1, c2, c3, c4, c5, min_value
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, c1, c2, c3, c4, c5
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, c1, c2, c3, c4, c5
    );
`endif
endinterface

// File: rtl/min_compare_seq.sv
// Serial six-sample comparison tree producing C1..C5 (pair, semifinal, final) for the colour index decoder.
// Optional MINCMP_MINVAL_EN adds the overall minimum value register and output.
module min_compare_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_clear,
    min_compare_seq_if.slave s_bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PAIR  = 3'd2,
        ST_SEMI  = 3'd3,
        ST_FINAL = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_cnt;
    logic [DATA_WIDTH-1:0] w_samp [6];
    logic [DATA_WIDTH-1:0] r_m01;
    logic [DATA_WIDTH-1:0] r_m23;
    logic [DATA_WIDTH-1:0] r_m45;
    logic [DATA_WIDTH-1:0] r_w;
    logic                  r_c1;
    logic                  r_c2;
    logic                  r_c3;
    logic                  r_c4;
    logic                  r_c5;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;

    assign w_in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_out_valid = (r_state == ST_HOLD);
    // clear wins over any handshake offered in the same cycle
    assign w_accept    = s_bus.in_valid & w_in_ready & ~i_clear;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_LOAD;
            ST_LOAD:  if (w_accept && (r_cnt == 3'd5)) w_state_next = ST_PAIR;
            ST_PAIR:  w_state_next = ST_SEMI;
            ST_SEMI:  w_state_next = ST_FINAL;
            ST_FINAL: w_state_next = ST_HOLD;
            ST_HOLD:  if (s_bus.out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (i_clear) begin
            w_state_next = ST_IDLE;
        end
    end

    // Counter returns to 0 after R5 so the next frame's R0 lands in slot 0.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= 3'd0;
        end else if (i_clear) begin
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            r_cnt <= (r_cnt == 3'd5) ? 3'd0 : r_cnt + 3'd1;
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_samp
        logic [DATA_WIDTH-1:0] r_val;
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_val <= '0;
            end else if (w_accept && (r_cnt == 3'(gi))) begin
                r_val <= s_bus.in_data;
            end
        end
        assign w_samp[gi] = r_val;
    end

`ifdef MINCMP_MINVAL_EN
    logic [DATA_WIDTH-1:0] r_min;
`endif

    // Strict less-than everywhere: a tie keeps the lower-index operand and leaves the flag at 0.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_c1  <= 1'b0;
            r_c2  <= 1'b0;
            r_c3  <= 1'b0;
            r_c4  <= 1'b0;
            r_c5  <= 1'b0;
            r_m01 <= '0;
            r_m23 <= '0;
            r_m45 <= '0;
            r_w   <= '0;
`ifdef MINCMP_MINVAL_EN
            r_min <= '0;
`endif
        end else if (!i_clear) begin
            case (r_state)
                ST_PAIR: begin
                    r_c1  <= (w_samp[1] < w_samp[0]);
                    r_c2  <= (w_samp[3] < w_samp[2]);
                    r_c3  <= (w_samp[5] < w_samp[4]);
                    r_m01 <= (w_samp[1] < w_samp[0]) ? w_samp[1] : w_samp[0];
                    r_m23 <= (w_samp[3] < w_samp[2]) ? w_samp[3] : w_samp[2];
                    r_m45 <= (w_samp[5] < w_samp[4]) ? w_samp[5] : w_samp[4];
                end
                ST_SEMI: begin
                    r_c4 <= (r_m23 < r_m01);
                    r_w  <= (r_m23 < r_m01) ? r_m23 : r_m01;
                end
                ST_FINAL: begin
                    r_c5  <= (r_m45 < r_w);
`ifdef MINCMP_MINVAL_EN
                    r_min <= (r_m45 < r_w) ? r_m45 : r_w;
`endif
                end
                default: ;
            endcase
        end
    end

    assign s_bus.in_ready  = w_in_ready;
    assign s_bus.out_valid = w_out_valid;
    assign s_bus.c1        = r_c1;
    assign s_bus.c2        = r_c2;
    assign s_bus.c3        = r_c3;
    assign s_bus.c4        = r_c4;
    assign s_bus.c5        = r_c5;
`ifdef MINCMP_MINVAL_EN
    assign s_bus.min_value = r_min;
`endif

endmodule

// File: doc/min_compare_seq.md
# min_compare_seq

Sequential comparison-tree engine that produces the five comparison flags consumed by the colour-classification minimum-index decoder. It accepts six unsigned distance samples R0..R5 serially over a valid/ready stream, evaluates the pair/semifinal/final comparisons over successive cycles, and presents C1..C5 (plus optionally the winning value) on a valid/ready output held until consumed. It sits between the per-face distance calculator and the index decoder in the sticker-colour path.

## Interface

- DATA_WIDTH, 8, width of each distance sample
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; returns to IDLE, discards partial frame
- in_valid  in  1  sample R[k] present on in_data
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_WIDTH  sample, unsigned; frame order R0,R1,...,R5
- out_valid  out  1  C1..C5 valid
- out_ready  in  1  consumer takes the result
- c1  out  1  1 when R1 < R0
- c2  out  1  1 when R3 < R2
- c3  out  1  1 when R5 < R4
- c4  out  1  1 when min(R2,R3) < min(R0,R1)
- c5  out  1  1 when min(R4,R5) < winner of c4 stage
- min_value  out  DATA_WIDTH  overall minimum (only with MINCMP_MINVAL_EN)

## Operation

- States: IDLE, LOAD, PAIR, SEMI, FINAL, HOLD.
- IDLE: in_ready=1; first handshake (in_valid & in_ready) stores R0, counter=1, go LOAD.
- LOAD: in_ready=1; each handshake stores R[counter], counter++; handshake at counter==5 stores R5, go PAIR. No handshake: stay, no change.
- PAIR (1 cycle): register c1,c2,c3 and pair minima m01, m23, m45.
- SEMI (1 cycle): register c4 = (m23 < m01); w = c4 ? m23 : m01.
- FINAL (1 cycle): register c5 = (m45 < w); min = c5 ? m45 : w.
- HOLD: out_valid=1; on out_ready go IDLE.
- in_ready=0 in PAIR, SEMI, FINAL, HOLD; samples offered there are not accepted.
- All comparisons strict unsigned less-than; ties select lower index (flag stays 0).
- Flags and min_value stable throughout HOLD; retain last values after leaving HOLD until next frame's PAIR/SEMI/FINAL overwrite them.
- clear has priority over every handshake; in HOLD it drops out_valid next cycle without requiring out_ready.

## Timing

- Reset (async, reset_n=0): state IDLE, counter 0, in_ready=1, out_valid=0, c1..c5=0, min_value=0, sample registers 0.
- Latency: 6th sample accepted at edge T → out_valid high after edge T+3 (PAIR, SEMI, FINAL each one cycle).
- Minimum frame period with continuous streaming and out_ready=1: 10 cycles (6 load, 3 compute, 1 hold).
- out_valid and out_ready both 1 at edge → result consumed; in_ready=1 the following cycle (not same cycle).
- reset_n asserted mid-frame or mid-HOLD: immediate return to reset values; partial frame lost; no spurious out_valid after release.
- reset_n deassertion synchronised externally; block does not re-synchronise.

## Configuration

- MINCMP_MINVAL_EN defined: min_value port and its FINAL-stage register present; behaviour as above.
- Not defined: min_value port absent, m45/w registers kept only as needed for c4/c5; c1..c5 timing identical.

## Test plan

- Frame R=10,20,30,40,50,60, out_ready=1 → c1..c5=0,0,0,0,0, min_value=10, out_valid 3 cycles after R5.
- Frame R=9,3,7,8,2,1 → c1=1,c2=0,c3=1,c4=0,c5=1, min_value=1.
- Ties R=5,5,5,5,5,5 → all flags 0, min_value=5; R=4,4,2,2,9,9 → c4=1, others 0.
- Backpressure: out_ready=0 for 20 cycles in HOLD → out_valid and flags stable, in_ready=0, extra in_valid ignored; next frame loads correctly after release.
- in_valid gaps: R0..R5 with 1–3 idle cycles between → same flags as gapless frame.
- Abort: reset_n low after R3, then clear after R2 of a second attempt → state IDLE, out_valid never asserted, following full frame 1,2,3,4,5,0 gives c5=1, c3=1, min_value=0.
